// File: rtl/io_uart_if.sv
// Op/done handshake and data bus between ctrl and the serial I/O unit.
// ctrl drives op and bus_data_in; the unit returns registered data and a done pulse.
interface io_uart_if #(
  parameter int DATA_BUS_WIDTH = 8
);
  logic [1:0]                op;
  logic [DATA_BUS_WIDTH-1:0] bus_data_in;
  logic [DATA_BUS_WIDTH-1:0] bus_data_out;
  logic                      op_done_out;

  modport master (
    output op,
    output bus_data_in,
    input  bus_data_out,
    input  op_done_out
  );

  modport slave (
    input  op,
    input  bus_data_in,
    output bus_data_out,
    output op_done_out
  );
endinterface

// File: rtl/io_uart.sv
// Byte-wide 8N1 UART: WRITE shifts a bus byte out, READ returns a received byte,
// STATUS returns {4'b0, frame_err, overrun, rx_valid, tx_busy} with clear-on-read errors.
module io_uart #(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int CLKS_PER_BIT   = 16
) (
  input  logic     clock,
  input  logic     reset,
  io_uart_if.slave bus,
  input  logic     uart_rx,
  output logic     uart_tx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;
  localparam logic [1:0] OP_STATUS = 2'b11;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'b00,
    TX_START = 2'b01,
    TX_DATA  = 2'b10,
    TX_STOP  = 2'b11
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'b000,
    RX_START = 3'b001,
    RX_DATA  = 3'b010,
    RX_STOP  = 3'b011,
    RX_BREAK = 3'b100
  } rx_state_e;

  tx_state_e                 tx_state_r, tx_state_s;
  logic [CNT_W-1:0]          tx_cnt_r, tx_cnt_s;
  logic [2:0]                tx_idx_r, tx_idx_s;
  logic [DATA_BUS_WIDTH-1:0] tx_byte_r, tx_byte_s;
  logic                      uart_tx_r, tx_line_s;
  logic                      tx_busy_s;

  logic                      rx_sync1_r, rx_sync2_r, rx_prev_r;
  logic                      rx_fall_s;
  rx_state_e                 rx_state_r, rx_state_s;
  logic [CNT_W-1:0]          rx_cnt_r, rx_cnt_s;
  logic [2:0]                rx_idx_r, rx_idx_s;
  logic [DATA_BUS_WIDTH-1:0] rx_shift_r, rx_shift_s;
  logic                      rx_done_s, rx_ferr_s;

  logic [DATA_BUS_WIDTH-1:0] rx_data_r, rx_data_s;
  logic                      rx_valid_r, rx_valid_s;
  logic                      overrun_r, overrun_s, overrun_set_s;
  logic                      frame_err_r, frame_err_s;
  logic [DATA_BUS_WIDTH-1:0] data_out_r, data_out_s;
  logic                      op_done_r, op_done_s;

  logic                      write_acc_s, read_acc_s, status_acc_s;

  assign tx_busy_s        = (tx_state_r != TX_IDLE);
  assign rx_fall_s        = rx_prev_r & ~rx_sync2_r;
  assign uart_tx          = uart_tx_r;
  assign bus.bus_data_out = data_out_r;
  assign bus.op_done_out  = op_done_r;

  // Op acceptance; the op still on the bus during the done cycle is ignored.
  always_comb begin
    write_acc_s  = 1'b0;
    read_acc_s   = 1'b0;
    status_acc_s = 1'b0;
    if (!op_done_r) begin
      case (bus.op)
        OP_WRITE:  write_acc_s  = ~tx_busy_s;
        OP_READ:   read_acc_s   = rx_valid_r;
        OP_STATUS: status_acc_s = 1'b1;
        default:   write_acc_s  = 1'b0;
      endcase
    end else begin
      write_acc_s = 1'b0;
    end
  end

  // Transmit FSM next state; the line value is derived from the next state so uart_tx stays a flop.
  always_comb begin
    tx_state_s = tx_state_r;
    tx_cnt_s   = tx_cnt_r;
    tx_idx_s   = tx_idx_r;
    tx_byte_s  = tx_byte_r;
    tx_line_s  = 1'b1;
    case (tx_state_r)
      TX_IDLE: begin
        tx_cnt_s = '0;
        if (write_acc_s) begin
          tx_state_s = TX_START;
          tx_byte_s  = bus.bus_data_in;
        end else begin
          tx_state_s = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_state_s = TX_DATA;
          tx_cnt_s   = '0;
          tx_idx_s   = 3'd0;
        end else begin
          tx_cnt_s = tx_cnt_r + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_cnt_s = '0;
          if (tx_idx_r == 3'd7) begin
            tx_state_s = TX_STOP;
          end else begin
            tx_idx_s = tx_idx_r + 3'd1;
          end
        end else begin
          tx_cnt_s = tx_cnt_r + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_state_s = TX_IDLE;
          tx_cnt_s   = '0;
        end else begin
          tx_cnt_s = tx_cnt_r + CNT_W'(1);
        end
      end
      default: begin
        tx_state_s = TX_IDLE;
        tx_cnt_s   = '0;
      end
    endcase
    case (tx_state_s)
      TX_START: tx_line_s = 1'b0;
      TX_DATA:  tx_line_s = tx_byte_s[tx_idx_s];
      default:  tx_line_s = 1'b1;
    endcase
  end

  // Receive FSM next state; samples land mid-bit, half a bit after the synchronized falling edge.
  always_comb begin
    rx_state_s = rx_state_r;
    rx_cnt_s   = rx_cnt_r;
    rx_idx_s   = rx_idx_r;
    rx_shift_s = rx_shift_r;
    rx_done_s  = 1'b0;
    rx_ferr_s  = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        rx_cnt_s = '0;
        if (rx_fall_s) begin
          rx_state_s = RX_START;
        end else begin
          rx_state_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_r == HALF_LAST) begin
          rx_cnt_s   = '0;
          rx_idx_s   = 3'd0;
          rx_state_s = rx_sync2_r ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_r == BIT_LAST) begin
          rx_cnt_s   = '0;
          rx_shift_s = {rx_sync2_r, rx_shift_r[DATA_BUS_WIDTH-1:1]};
          if (rx_idx_r == 3'd7) begin
            rx_state_s = RX_STOP;
          end else begin
            rx_idx_s = rx_idx_r + 3'd1;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_r == BIT_LAST) begin
          rx_cnt_s = '0;
          if (rx_sync2_r) begin
            rx_done_s  = 1'b1;
            rx_state_s = RX_IDLE;
          end else begin
            rx_ferr_s  = 1'b1;
            rx_state_s = RX_BREAK;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_W'(1);
        end
      end
      RX_BREAK: begin
        rx_cnt_s = '0;
        if (rx_sync2_r) begin
          rx_state_s = RX_IDLE;
        end else begin
          rx_state_s = RX_BREAK;
        end
      end
      default: begin
        rx_state_s = RX_IDLE;
        rx_cnt_s   = '0;
      end
    endcase
  end

  // Holding register, sticky flags and bus response; a READ on the completion edge frees the slot.
  always_comb begin
    rx_data_s     = rx_data_r;
    rx_valid_s    = rx_valid_r;
    overrun_set_s = 1'b0;
    if (rx_done_s && (!rx_valid_r || read_acc_s)) begin
      rx_data_s  = rx_shift_r;
      rx_valid_s = 1'b1;
    end else if (rx_done_s) begin
      overrun_set_s = 1'b1;
    end else if (read_acc_s) begin
      rx_valid_s = 1'b0;
    end else begin
      rx_valid_s = rx_valid_r;
    end
    overrun_s   = status_acc_s ? overrun_set_s : (overrun_r | overrun_set_s);
    frame_err_s = status_acc_s ? rx_ferr_s : (frame_err_r | rx_ferr_s);
    op_done_s   = write_acc_s | read_acc_s | status_acc_s;
    if (read_acc_s) begin
      data_out_s = rx_data_r;
    end else if (status_acc_s) begin
      data_out_s = {4'b0000, frame_err_r, overrun_r, rx_valid_r, tx_busy_s};
    end else begin
      data_out_s = data_out_r;
    end
  end

  // State registers; reset idles both FSMs and forces the line high immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state_r  <= TX_IDLE;
      tx_cnt_r    <= '0;
      tx_idx_r    <= 3'd0;
      tx_byte_r   <= '0;
      uart_tx_r   <= 1'b1;
      rx_sync1_r  <= 1'b1;
      rx_sync2_r  <= 1'b1;
      rx_prev_r   <= 1'b1;
      rx_state_r  <= RX_IDLE;
      rx_cnt_r    <= '0;
      rx_idx_r    <= 3'd0;
      rx_shift_r  <= '0;
      rx_data_r   <= '0;
      rx_valid_r  <= 1'b0;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
      data_out_r  <= '0;
      op_done_r   <= 1'b0;
    end else begin
      tx_state_r  <= tx_state_s;
      tx_cnt_r    <= tx_cnt_s;
      tx_idx_r    <= tx_idx_s;
      tx_byte_r   <= tx_byte_s;
      uart_tx_r   <= tx_line_s;
      rx_sync1_r  <= uart_rx;
      rx_sync2_r  <= rx_sync1_r;
      rx_prev_r   <= rx_sync2_r;
      rx_state_r  <= rx_state_s;
      rx_cnt_r    <= rx_cnt_s;
      rx_idx_r    <= rx_idx_s;
      rx_shift_r  <= rx_shift_s;
      rx_data_r   <= rx_data_s;
      rx_valid_r  <= rx_valid_s;
      overrun_r   <= overrun_s;
      frame_err_r <= frame_err_s;
      data_out_r  <= data_out_s;
      op_done_r   <= op_done_s;
    end
  end

endmodule

// File: tb/tb_io_uart.sv
// Scoreboard bench for io_uart: ops push expected responses, monitors on op_done and
// on uart_tx pop and compare against a frame/flag-level model of the unit.
module tb_io_uart;
  localparam int C = 4;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;
  localparam logic [1:0] OP_STATUS = 2'b11;

  typedef struct packed { logic [1:0] op; logic [7:0] exp; } op_exp_t;
  typedef struct packed { logic [7:0] b; logic [31:0] start; } tx_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rx_drv, loop_en;
  logic uart_tx_w, uart_rx_w;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  op_exp_t op_q[$];
  tx_exp_t tx_q[$];
  bit      tx_abort = 1'b0;

  // reference model state: holding slot, sticky flags, last bus value, last tx accept edge
  bit       m_valid, m_ovr, m_ferr;
  logic [7:0] m_byte, m_last;
  int       m_tx_acc;

  io_uart_if #(.DATA_BUS_WIDTH(8)) bus_if ();

  io_uart #(.DATA_BUS_WIDTH(8), .CLKS_PER_BIT(C)) dut (
    .clock   (clk),
    .reset   (rst_n),
    .bus     (bus_if),
    .uart_rx (uart_rx_w),
    .uart_tx (uart_tx_w)
  );

  assign uart_rx_w = loop_en ? uart_tx_w : rx_drv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    m_byte = 8'h00; m_last = 8'h00; m_tx_acc = -1000;
  endtask

  // issue one op and hold it until done or until the cycle budget runs out
  task automatic do_op(input logic [1:0] o, input logic [7:0] din, input int budget);
    int c, acc;
    bit seen, want;
    logic [7:0] exp;
    @(posedge clk); #1;
    c = cyc;
    want = 1'b1;
    exp = m_last;
    case (o)
      OP_WRITE: begin
        acc = (c + 1 > m_tx_acc + 10 * C + 1) ? c + 1 : m_tx_acc + 10 * C + 1;
        tx_q.push_back('{din, acc});
        m_tx_acc = acc;
      end
      OP_STATUS: begin
        exp = {4'b0000, m_ferr, m_ovr, m_valid,
               (c + 1 > m_tx_acc) && (c + 1 <= m_tx_acc + 10 * C)};
        m_ferr = 1'b0; m_ovr = 1'b0; m_last = exp;
      end
      default: begin
        want = m_valid;
        if (m_valid) begin exp = m_byte; m_last = m_byte; m_valid = 1'b0; end
      end
    endcase
    if (want) op_q.push_back('{o, exp});
    bus_if.op = o;
    bus_if.bus_data_in = din;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = bus_if.op_done_out;
    end
    if (want) check("op_done_within_budget", {31'd0, seen}, 32'd1);
    else      check("read_stalls_without_byte", {31'd0, seen}, 32'd0);
    @(posedge clk); #1;
    bus_if.op = 2'b00;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit upd);
    logic [9:0] f;
    f = {stop_ok, b, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (C) @(posedge clk);
      #1;
    end
    rx_drv = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    if (upd) begin
      if (!stop_ok)      m_ferr = 1'b1;
      else if (m_valid)  m_ovr = 1'b1;
      else begin m_byte = b; m_valid = 1'b1; end
    end
  endtask

  // bus response monitor
  always @(negedge clk) begin
    op_exp_t e;
    if (rst_n === 1'b1 && bus_if.op_done_out === 1'b1) begin
      if (op_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done: op_done with nothing pending, op=%0d data=0x%0h", bus_if.op, bus_if.bus_data_out);
      end else begin
        e = op_q.pop_front();
        case (e.op)
          OP_WRITE:  check("write_keeps_bus_data", {24'd0, bus_if.bus_data_out}, {24'd0, e.exp});
          OP_READ:   check("read_data", {24'd0, bus_if.bus_data_out}, {24'd0, e.exp});
          default:   check("status_data", {24'd0, bus_if.bus_data_out}, {24'd0, e.exp});
        endcase
      end
    end
  end

  // serial output monitor: captures a whole frame at clock resolution
  initial begin : tx_mon
    logic [10*C-1:0] smp;
    logic [9:0] fb;
    int st, bad;
    tx_exp_t te;
    @(posedge rst_n);
    forever begin
      @(negedge clk);
      if (uart_tx_w === 1'b0) begin
        st = cyc;
        smp[0] = uart_tx_w;
        for (int i = 1; i < 10 * C; i++) begin
          @(negedge clk);
          smp[i] = uart_tx_w;
        end
        if (tx_abort) begin
          tx_abort = 1'b0;
        end else if (tx_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL tx_unexpected_frame: start at cycle %0d, no WRITE pending", st);
        end else begin
          te = tx_q.pop_front();
          fb = {1'b1, te.b, 1'b0};
          bad = 0;
          for (int i = 0; i < 10 * C; i++) if (smp[i] !== fb[i / C]) bad++;
          check("tx_wave_bad_samples", bad, 0);
          check("tx_start_cycle", st, te.start);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b, rb;
    rst_n = 1'b1; rx_drv = 1'b1; loop_en = 1'b0;
    bus_if.op = 2'b00; bus_if.bus_data_in = 8'h00;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("reset_uart_tx", {31'd0, uart_tx_w}, 32'd1);
    check("reset_bus_data", {24'd0, bus_if.bus_data_out}, 32'd0);
    check("reset_op_done", {31'd0, bus_if.op_done_out}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    do_op(OP_STATUS, 8'h00, 10);
    check("idle_uart_tx", {31'd0, uart_tx_w}, 32'd1);

    do_op(OP_WRITE, 8'hA5, 10);
    do_op(OP_STATUS, 8'h00, 10);
    repeat (50) @(posedge clk);
    do_op(OP_STATUS, 8'h00, 10);

    send_frame(8'h3C, 1'b1, 1'b1);
    do_op(OP_READ, 8'h00, 10);
    do_op(OP_READ, 8'h00, 20);
    b = 8'($urandom);
    m_byte = b; m_valid = 1'b1;
    fork
      send_frame(b, 1'b1, 1'b0);
      do_op(OP_READ, 8'h00, 80);
    join

    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    do_op(OP_STATUS, 8'h00, 10);
    do_op(OP_READ, 8'h00, 10);
    do_op(OP_STATUS, 8'h00, 10);

    send_frame(8'($urandom), 1'b0, 1'b1);
    do_op(OP_STATUS, 8'h00, 10);
    @(posedge clk); #1 rx_drv = 1'b0;
    @(posedge clk); #1 rx_drv = 1'b1;
    repeat (20) @(posedge clk);
    do_op(OP_STATUS, 8'h00, 10);
    do_op(OP_READ, 8'h00, 20);

    for (int it = 0; it < 5; it++) begin
      b = 8'($urandom);
      rb = 8'($urandom);
      do_op(OP_WRITE, b, 20);
      send_frame(rb, 1'b1, 1'b1);
      do_op(OP_STATUS, 8'h00, 10);
      do_op(OP_READ, 8'h00, 10);
    end

    loop_en = 1'b1;
    b = 8'($urandom);
    repeat (5) @(posedge clk);
    do_op(OP_WRITE, 8'h5A, 20);
    do_op(OP_WRITE, b, 60);
    m_byte = 8'h5A; m_valid = 1'b1;
    do_op(OP_READ, 8'h00, 60);
    m_byte = b; m_valid = 1'b1;
    do_op(OP_READ, 8'h00, 80);

    do_op(OP_WRITE, 8'($urandom), 20);
    repeat (12) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midframe_reset_uart_tx", {31'd0, uart_tx_w}, 32'd1);
    check("midframe_reset_bus_data", {24'd0, bus_if.bus_data_out}, 32'd0);
    tx_q.delete();
    tx_abort = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (50) @(posedge clk);
    do_op(OP_STATUS, 8'h00, 10);
    loop_en = 1'b0;

    repeat (10) @(posedge clk);
    check("op_queue_drained", op_q.size(), 0);
    check("tx_queue_drained", tx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/io_uart.md
Name: io_uart

Overview:
Byte-wide serial I/O unit that acts as the CPU's third data source and sink.
- Consumes bytes driven on the shared data bus by ctrl-issued WRITE ops and shifts them out as 8N1 UART frames.
- Receives 8N1 frames and returns them on bus_data_out, which feeds the mux I/O input.
- Handshakes with ctrl the same way the memory unit does: op held until a one-cycle op_done_out.

Parameters:
DATA_BUS_WIDTH, 8, bus width; only 8 is supported.
CLKS_PER_BIT, 16, clock cycles per UART bit; must be even and >= 4.

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
op  input  2  io op: 00 NOP, 01 WRITE, 10 READ, 11 STATUS
bus_data_in  input  8  shared data bus, sampled on WRITE accept
bus_data_out  output  8  registered read/status data to the mux I/O input
op_done_out  output  1  one-cycle completion pulse for the current op
uart_rx  input  1  serial in, asynchronous, idle high
uart_tx  output  1  serial out, idle high

Behaviour:
- Reset (reset=0, asynchronous): uart_tx=1, bus_data_out=0, op_done_out=0. tx and rx FSMs go IDLE. rx_valid, overrun and frame_err are cleared. Synchronizer flops are set to 1.
- Op acceptance: an op is evaluated only in cycles where op_done_out=0. ctrl holds op until it sees op_done_out=1. An op still present during the op_done_out cycle is ignored.
- WRITE:
  - If tx FSM is IDLE: latch bus_data_in, tx FSM -> START, op_done_out=1 next cycle.
  - If tx is busy: stall with no done until tx returns to IDLE.
- READ:
  - If rx_valid=1: bus_data_out <= rx_data, rx_valid <= 0, op_done_out=1 next cycle.
  - Otherwise stall.
- STATUS:
  - Always completes; op_done_out=1 next cycle.
  - bus_data_out <= {4'b0, frame_err, overrun, rx_valid, tx_busy}.
  - overrun and frame_err are cleared on the same edge (clear-on-read). If a new error event lands on that edge, the flag stays set.
- bus_data_out holds its value until the next READ or STATUS completes.
- tx FSM (IDLE -> START -> DATA -> STOP -> IDLE):
  - Each state lasts CLKS_PER_BIT cycles, timed by a baud counter.
  - START drives 0. DATA drives bits 0..7, LSB first, using a 3-bit index. STOP drives 1.
  - tx_busy = (state != IDLE).
  - The first start-bit cycle on uart_tx is the cycle after the accept edge.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - A WRITE held during STOP is accepted on the first IDLE cycle, giving back-to-back frames.
- rx FSM (IDLE -> START -> DATA -> STOP -> IDLE):
  - uart_rx passes through a 2-flop synchronizer.
  - IDLE: a synchronized 1->0 edge enters START.
  - START: after CLKS_PER_BIT/2 cycles, sample. If 1, treat as a glitch and return to IDLE with no flag. If 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles into a shift register, LSB first, 8 bits.
  - STOP: sample after CLKS_PER_BIT cycles.
    - Sample = 1 and rx_valid = 0: rx_data <= byte, rx_valid <= 1.
    - Sample = 1 and rx_valid = 1: discard the new byte, keep the old rx_data, set overrun.
    - Sample = 0: discard the byte, set frame_err, and wait for the synchronized line to return high before IDLE.
- Simultaneous events:
  - READ accept and rx byte completion on the same edge: the READ returns the old byte, the new byte loads, rx_valid stays 1, no overrun.
  - STATUS on the same edge reports the pre-edge flags.
- reset asserted mid-frame: both FSMs abort immediately, uart_tx=1 asynchronously, and any partial byte is lost.
- tx and rx are fully independent; loopback (uart_tx tied to uart_rx) must work.

Test Plan:
- Reset, then STATUS with CLKS_PER_BIT=4 -> op_done one cycle later, bus_data_out=0x00, uart_tx=1.
- WRITE 0xA5 -> done next cycle; uart_tx shows 0,1,0,1,0,0,1,0,1,1 at 4 cycles/bit (40 cycles); STATUS bit0=1 during the frame and 0 after.
- Drive rx frame 0x3C, then READ -> bus_data_out=0x3C with done; a second READ stalls with no done until the next frame arrives.
- Two rx frames 0x11 then 0x22 with no READ -> STATUS=0x06 (overrun, rx_valid); READ returns 0x11; a second STATUS returns 0x00.
- rx frame with stop bit 0 -> STATUS bit3=1, rx_valid=0; a 1-cycle low glitch on uart_rx -> no flags, no byte.
- Loopback: WRITE 0x5A, second WRITE issued during the first frame stalls until IDLE; READ twice returns 0x5A then the second byte. Assert reset mid-frame -> uart_tx=1 immediately, STATUS=0x00 after release.
